// File: rtl/du_mem_dump_tx.sv
// Debug-unit memory dump serializer: optional header word, then a run of memory
// words split into UART bytes for the shared Tx FIFO, closed by an XOR checksum byte.
`timescale 1ns/1ps
module du_mem_dump_tx #(
    parameter int NB_WORD      = 32,
    parameter int NB_UART_DATA = 8,
    parameter int NB_ADDR      = 8,
    parameter int NB_COUNT     = 9,
    parameter int ADDR_STEP    = 1
) (
    input  logic                    clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    input  logic [NB_ADDR-1:0]      i_base_addr,
    input  logic [NB_COUNT-1:0]     i_count,
    input  logic                    i_big_endian,
    input  logic                    i_hdr_en,
    input  logic [NB_WORD-1:0]      i_hdr_word,
    input  logic                    i_abort,
    input  logic                    i_fifo_full,
    input  logic [NB_WORD-1:0]      i_mem_data,
    output logic                    o_mem_rd,
    output logic [NB_ADDR-1:0]      o_mem_raddr,
    output logic                    o_wr,
    output logic [NB_UART_DATA-1:0] o_wdata,
    output logic                    o_tx_start,
    output logic                    o_busy,
    output logic                    o_done
);
    localparam int NBYTES  = NB_WORD / NB_UART_DATA;
    localparam int NB_BCNT = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [2:0] {
        ST_IDLE, ST_READ, ST_WAIT, ST_SEND, ST_CSUM, ST_DONE
    } state_t;

    state_t                  state, state_next;
    logic [NB_ADDR-1:0]      addr;
    logic [NB_COUNT-1:0]     words_left;
    logic [NB_WORD-1:0]      shreg;
    logic [NB_UART_DATA-1:0] csum;
    logic [NB_BCNT-1:0]      byte_cnt;
    logic                    big_endian;
    logic                    tx_started;
    logic                    last_byte;
    logic [NB_UART_DATA-1:0] cur_byte;

    assign last_byte = (byte_cnt == NB_BCNT'(NBYTES - 1));
    assign cur_byte  = big_endian ? shreg[NB_WORD-1 -: NB_UART_DATA] : shreg[NB_UART_DATA-1:0];
    assign o_busy    = (state == ST_READ) || (state == ST_WAIT) ||
                       (state == ST_SEND) || (state == ST_CSUM);
    assign o_done    = (state == ST_DONE) && !i_abort;

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next  = state;
        o_mem_rd    = 1'b0;
        o_mem_raddr = '0;
        o_wr        = 1'b0;
        o_wdata     = '0;
        case (state)
            ST_IDLE: begin
                if (i_start) begin
                    if (i_hdr_en)          state_next = ST_SEND;
                    else if (i_count == 0) state_next = ST_CSUM;
                    else                   state_next = ST_READ;
                end
            end
            ST_READ: begin
                o_mem_rd   = 1'b1;
                state_next = ST_WAIT;
            end
            ST_WAIT: state_next = ST_SEND;
            ST_SEND: begin
                if (!i_fifo_full) begin
                    o_wr    = 1'b1;
                    o_wdata = cur_byte;
                    if (last_byte) state_next = (words_left != 0) ? ST_READ : ST_CSUM;
                end
            end
            ST_CSUM: begin
                if (!i_fifo_full) begin
                    o_wr       = 1'b1;
                    o_wdata    = csum;
                    state_next = ST_DONE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
        // Abort wins over any pending write or read in the same cycle.
        if (i_abort && state != ST_IDLE) begin
            state_next = ST_IDLE;
            o_wr       = 1'b0;
            o_wdata    = '0;
            o_mem_rd   = 1'b0;
        end
        if (o_mem_rd) o_mem_raddr = addr;
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            addr       <= '0;
            words_left <= '0;
            shreg      <= '0;
            csum       <= '0;
            byte_cnt   <= '0;
            big_endian <= 1'b0;
            tx_started <= 1'b0;
            o_tx_start <= 1'b0;
        end else begin
            o_tx_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        addr       <= i_base_addr;
                        words_left <= i_count;
                        big_endian <= i_big_endian;
                        csum       <= '0;
                        byte_cnt   <= '0;
                        tx_started <= 1'b0;
                        if (i_hdr_en) shreg <= i_hdr_word;
                    end
                end
                ST_WAIT: begin
                    shreg      <= i_mem_data;
                    addr       <= addr + NB_ADDR'(ADDR_STEP);
                    words_left <= words_left - NB_COUNT'(1);
                    byte_cnt   <= '0;
                end
                ST_SEND: begin
                    if (o_wr) begin
                        shreg    <= big_endian ? (shreg << NB_UART_DATA) : (shreg >> NB_UART_DATA);
                        csum     <= csum ^ cur_byte;
                        byte_cnt <= last_byte ? '0 : byte_cnt + NB_BCNT'(1);
                    end
                end
                default: ;
            endcase
            // Kick the transmitter once per transfer, the cycle after its first byte.
            if (o_wr && !tx_started) begin
                tx_started <= 1'b1;
                o_tx_start <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_du_mem_dump_tx.sv
// Directed self-checking bench for du_mem_dump_tx (32-bit words, byte-addressed step 4).
`timescale 1ns/1ps
module tb_du_mem_dump_tx;
    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_start = 1'b0;
    logic [7:0]  i_base_addr = '0;
    logic [8:0]  i_count = '0;
    logic        i_big_endian = 1'b0;
    logic        i_hdr_en = 1'b0;
    logic [31:0] i_hdr_word = '0;
    logic        i_abort = 1'b0;
    logic        i_fifo_full = 1'b0;
    logic [31:0] i_mem_data = '0;
    logic        o_mem_rd;
    logic [7:0]  o_mem_raddr;
    logic        o_wr;
    logic [7:0]  o_wdata;
    logic        o_tx_start;
    logic        o_busy;
    logic        o_done;

    du_mem_dump_tx #(.NB_WORD(32), .NB_UART_DATA(8), .NB_ADDR(8), .NB_COUNT(9), .ADDR_STEP(4)) dut (
        .clk(clk), .i_rst(i_rst), .i_start(i_start), .i_base_addr(i_base_addr),
        .i_count(i_count), .i_big_endian(i_big_endian), .i_hdr_en(i_hdr_en),
        .i_hdr_word(i_hdr_word), .i_abort(i_abort), .i_fifo_full(i_fifo_full),
        .i_mem_data(i_mem_data), .o_mem_rd(o_mem_rd), .o_mem_raddr(o_mem_raddr),
        .o_wr(o_wr), .o_wdata(o_wdata), .o_tx_start(o_tx_start), .o_busy(o_busy),
        .o_done(o_done)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:255];
    always @(posedge clk) if (o_mem_rd) i_mem_data <= mem[o_mem_raddr];

    int errors = 0;
    int checks = 0;

    bit         full_at [64];
    bit         busy_log [64];
    int         abort_at, start2_at;
    logic [7:0] got_b [$];
    logic [7:0] got_a [$];
    int first_wr, tx_cyc, tx_cnt, done_cyc, done_cnt, wr_full, wdata_leak, raddr_leak;

    task automatic setup(input logic [7:0] base, input logic [8:0] cnt, input logic be,
                         input logic hdr_en, input logic [31:0] hdr);
        i_base_addr  = base;
        i_count      = cnt;
        i_big_endian = be;
        i_hdr_en     = hdr_en;
        i_hdr_word   = hdr;
        abort_at     = -1;
        start2_at    = -1;
        for (int i = 0; i < 64; i++) full_at[i] = 1'b0;
    endtask

    // Cycle 0 is the cycle in which i_start is presented; outputs sampled 1ns after the falling edge.
    task automatic run(input int ncyc);
        got_b.delete(); got_a.delete();
        first_wr = -1; tx_cyc = -1; tx_cnt = 0; done_cyc = -1; done_cnt = 0;
        wr_full = 0; wdata_leak = 0; raddr_leak = 0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            i_start     = (c == 0) || (c == start2_at);
            i_fifo_full = full_at[c];
            i_abort     = (c == abort_at);
            #1;
            if (o_wr) begin
                got_b.push_back(o_wdata);
                if (first_wr < 0) first_wr = c;
                if (i_fifo_full) wr_full++;
            end else if (o_wdata != 8'h00) wdata_leak++;
            if (o_mem_rd) got_a.push_back(o_mem_raddr);
            else if (o_mem_raddr != 8'h00) raddr_leak++;
            if (o_tx_start) begin tx_cnt++; tx_cyc = c; end
            if (o_done) begin done_cnt++; done_cyc = c; end
            busy_log[c] = o_busy;
        end
        i_start = 1'b0; i_fifo_full = 1'b0; i_abort = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] exp_b [9];
        exp_b = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h0F, 8'h0F, 8'hA5, 8'hA5, 8'h44};
        @(negedge clk); #1;
        checks++; if (o_wr !== 1'b0) begin errors++; $display("FAIL rst_wr: got %0h want 0", o_wr); end
        checks++; if (o_wdata !== 8'h00) begin errors++; $display("FAIL rst_wdata: got %0h want 0", o_wdata); end
        checks++; if (o_mem_rd !== 1'b0 || o_mem_raddr !== 8'h00) begin errors++; $display("FAIL rst_mem: got rd=%0h addr=%0h want 0", o_mem_rd, o_mem_raddr); end
        checks++; if ({o_busy, o_done, o_tx_start} !== 3'b000) begin errors++; $display("FAIL rst_ctrl: got %0b want 000", {o_busy, o_done, o_tx_start}); end
        i_rst = 1'b0;
        setup(8'h10, 9'd2, 1'b0, 1'b0, 32'h0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            i_start = (c == 0);
            #1;
        end
        checks++; if (o_wr !== 1'b1 || o_tx_start !== 1'b1) begin errors++; $display("FAIL rst_pre: got wr=%0h txs=%0h want 1 1", o_wr, o_tx_start); end
        #2 i_rst = 1'b1;
        #1;
        checks++; if (o_wr !== 1'b0 || o_wdata !== 8'h00) begin errors++; $display("FAIL rst_async_wr: got wr=%0h wdata=%0h want 0 0", o_wr, o_wdata); end
        checks++; if ({o_busy, o_tx_start, o_done, o_mem_rd} !== 4'b0000) begin errors++; $display("FAIL rst_async_ctrl: got %0b want 0000", {o_busy, o_tx_start, o_done, o_mem_rd}); end
        @(negedge clk);
        i_rst = 1'b0;
        run(20);
        checks++; if (got_b.size() != 9) begin errors++; $display("FAIL rst_restart_len: got %0d want 9", got_b.size()); end
        for (int i = 0; i < 9; i++) begin
            logic [7:0] g = (i < got_b.size()) ? got_b[i] : 8'hxx;
            checks++; if (g !== exp_b[i]) begin errors++; $display("FAIL rst_restart_byte%0d: got %0h want %0h", i, g, exp_b[i]); end
        end
        checks++; if (done_cyc != 14) begin errors++; $display("FAIL rst_restart_done: got %0d want 14", done_cyc); end
    endtask

    task automatic test_le_basic();
        logic [7:0] exp_b [9];
        exp_b = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h0F, 8'h0F, 8'hA5, 8'hA5, 8'h44};
        setup(8'h10, 9'd2, 1'b0, 1'b0, 32'h0);
        run(20);
        checks++; if (got_a.size() != 2) begin errors++; $display("FAIL le_nrd: got %0d want 2", got_a.size()); end
        else begin
            checks++; if (got_a[0] !== 8'h10 || got_a[1] !== 8'h14) begin errors++; $display("FAIL le_raddr: got %0h %0h want 10 14", got_a[0], got_a[1]); end
        end
        checks++; if (got_b.size() != 9) begin errors++; $display("FAIL le_len: got %0d want 9", got_b.size()); end
        for (int i = 0; i < 9; i++) begin
            logic [7:0] g = (i < got_b.size()) ? got_b[i] : 8'hxx;
            checks++; if (g !== exp_b[i]) begin errors++; $display("FAIL le_byte%0d: got %0h want %0h", i, g, exp_b[i]); end
        end
        checks++; if (first_wr != 3) begin errors++; $display("FAIL le_first_wr: got %0d want 3", first_wr); end
        checks++; if (tx_cnt != 1 || tx_cyc != 4) begin errors++; $display("FAIL le_tx_start: got n=%0d at %0d want 1 at 4", tx_cnt, tx_cyc); end
        checks++; if (done_cnt != 1 || done_cyc != 14) begin errors++; $display("FAIL le_done: got n=%0d at %0d want 1 at 14", done_cnt, done_cyc); end
        checks++; if (wdata_leak != 0 || raddr_leak != 0) begin errors++; $display("FAIL le_idle_zero: got wdata=%0d raddr=%0d want 0 0", wdata_leak, raddr_leak); end
        checks++; if (busy_log[0] !== 1'b0 || busy_log[1] !== 1'b1 || busy_log[13] !== 1'b1 || busy_log[14] !== 1'b0) begin
            errors++; $display("FAIL le_busy: got %0b%0b%0b%0b want 0110", busy_log[0], busy_log[1], busy_log[13], busy_log[14]); end
    endtask

    task automatic test_hdr_be();
        logic [7:0] exp_b [9];
        exp_b = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02, 8'h03, 8'h04, 8'h26};
        setup(8'h20, 9'd1, 1'b1, 1'b1, 32'hDEADBEEF);
        run(16);
        checks++; if (got_b.size() != 9) begin errors++; $display("FAIL hdr_len: got %0d want 9", got_b.size()); end
        for (int i = 0; i < 9; i++) begin
            logic [7:0] g = (i < got_b.size()) ? got_b[i] : 8'hxx;
            checks++; if (g !== exp_b[i]) begin errors++; $display("FAIL hdr_byte%0d: got %0h want %0h", i, g, exp_b[i]); end
        end
        checks++; if (got_a.size() != 1 || got_a[0] !== 8'h20) begin errors++; $display("FAIL hdr_raddr: got n=%0d want one read at 20", got_a.size()); end
        checks++; if (done_cyc != 12 || first_wr != 1) begin errors++; $display("FAIL hdr_timing: got done=%0d first=%0d want 12 1", done_cyc, first_wr); end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp_b [9];
        exp_b = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h0F, 8'h0F, 8'hA5, 8'hA5, 8'h44};
        setup(8'h10, 9'd2, 1'b0, 1'b0, 32'h0);
        full_at[5] = 1'b1; full_at[6] = 1'b1; full_at[7] = 1'b1; full_at[16] = 1'b1;
        run(24);
        checks++; if (got_b.size() != 9) begin errors++; $display("FAIL bp_len: got %0d want 9", got_b.size()); end
        for (int i = 0; i < 9; i++) begin
            logic [7:0] g = (i < got_b.size()) ? got_b[i] : 8'hxx;
            checks++; if (g !== exp_b[i]) begin errors++; $display("FAIL bp_byte%0d: got %0h want %0h", i, g, exp_b[i]); end
        end
        checks++; if (wr_full != 0) begin errors++; $display("FAIL bp_wr_full: got %0d want 0", wr_full); end
        checks++; if (done_cnt != 1 || done_cyc != 18) begin errors++; $display("FAIL bp_done: got n=%0d at %0d want 1 at 18", done_cnt, done_cyc); end
        checks++; if (tx_cnt != 1 || tx_cyc != 4) begin errors++; $display("FAIL bp_tx_start: got n=%0d at %0d want 1 at 4", tx_cnt, tx_cyc); end
    endtask

    task automatic test_zero_and_wrap();
        logic [7:0] exp_b [9];
        exp_b = '{8'hAA, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h55, 8'hFF};
        setup(8'h40, 9'd0, 1'b0, 1'b0, 32'h0);
        run(6);
        checks++; if (got_b.size() != 1 || got_b[0] !== 8'h00) begin errors++; $display("FAIL zero_write: got n=%0d want single 00", got_b.size()); end
        checks++; if (done_cyc != 2 || got_a.size() != 0) begin errors++; $display("FAIL zero_done: got done=%0d reads=%0d want 2 0", done_cyc, got_a.size()); end
        setup(8'hFC, 9'd2, 1'b0, 1'b0, 32'h0);
        run(20);
        checks++; if (got_a.size() != 2) begin errors++; $display("FAIL wrap_nrd: got %0d want 2", got_a.size()); end
        else begin
            checks++; if (got_a[0] !== 8'hFC || got_a[1] !== 8'h00) begin errors++; $display("FAIL wrap_raddr: got %0h %0h want fc 00", got_a[0], got_a[1]); end
        end
        for (int i = 0; i < 9; i++) begin
            logic [7:0] g = (i < got_b.size()) ? got_b[i] : 8'hxx;
            checks++; if (g !== exp_b[i]) begin errors++; $display("FAIL wrap_byte%0d: got %0h want %0h", i, g, exp_b[i]); end
        end
    endtask

    task automatic test_abort();
        logic [7:0] exp_b [9];
        exp_b = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h0F, 8'h0F, 8'hA5, 8'hA5, 8'h44};
        setup(8'h10, 9'd2, 1'b0, 1'b0, 32'h0);
        start2_at = 5;
        abort_at  = 10;
        run(16);
        checks++; if (got_b.size() != 5) begin errors++; $display("FAIL abort_len: got %0d want 5", got_b.size()); end
        for (int i = 0; i < 5; i++) begin
            logic [7:0] g = (i < got_b.size()) ? got_b[i] : 8'hxx;
            checks++; if (g !== exp_b[i]) begin errors++; $display("FAIL abort_byte%0d: got %0h want %0h", i, g, exp_b[i]); end
        end
        checks++; if (done_cnt != 0) begin errors++; $display("FAIL abort_done: got %0d want 0", done_cnt); end
        checks++; if (busy_log[10] !== 1'b1 || busy_log[11] !== 1'b0) begin errors++; $display("FAIL abort_busy: got %0b%0b want 10", busy_log[10], busy_log[11]); end
        setup(8'h10, 9'd2, 1'b0, 1'b0, 32'h0);
        run(20);
        checks++; if (got_b.size() != 9) begin errors++; $display("FAIL replay_len: got %0d want 9", got_b.size()); end
        for (int i = 0; i < 9; i++) begin
            logic [7:0] g = (i < got_b.size()) ? got_b[i] : 8'hxx;
            checks++; if (g !== exp_b[i]) begin errors++; $display("FAIL replay_byte%0d: got %0h want %0h", i, g, exp_b[i]); end
        end
        checks++; if (done_cnt != 1 || done_cyc != 14 || tx_cyc != 4) begin errors++; $display("FAIL replay_timing: got done=%0d@%0d txs@%0d want 1@14 txs@4", done_cnt, done_cyc, tx_cyc); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h10] = 32'h11223344;
        mem[8'h14] = 32'hA5A50F0F;
        mem[8'h20] = 32'h01020304;
        mem[8'hFC] = 32'h000000AA;
        mem[8'h00] = 32'h55000000;
        abort_at  = -1;
        start2_at = -1;
        test_reset();
        test_le_basic();
        test_hdr_be();
        test_backpressure();
        test_zero_and_wrap();
        test_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
